// File: rtl/stream_demux.sv
// stream_demux: 1-to-N valid/ready stream demultiplexer with a 2-entry FIFO
// per output channel, broadcast mode and a saturating drop counter for
// words addressed to a channel that does not exist.
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        drop_cnt
);

  if ((1 << SEL_W) < N_OUT) begin : g_sel_w_check
    $error("stream_demux: SEL_W too narrow to address N_OUT channels");
  end

  // Saturating increment for the drop counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [DATA_W-1:0] mem_q   [N_OUT][2];
  logic [1:0]        cnt_q   [N_OUT];
  logic [1:0]        cnt_d   [N_OUT];
  logic              wptr_q  [N_OUT];
  logic              wptr_d  [N_OUT];
  logic              rptr_q  [N_OUT];
  logic              rptr_d  [N_OUT];
  logic [CNT_W-1:0]  drop_q;
  logic [CNT_W-1:0]  drop_d;

  logic [N_OUT-1:0]  full;
  logic [N_OUT-1:0]  push;
  logic [N_OUT-1:0]  pop;
  logic              sel_full;
  logic              sel_in_range;
  logic              accept;

  // Input acceptance: depends only on occupancy and the routing inputs,
  // never on out_ready, so no combinational ready path crosses the block.
  always_comb begin
    full         = '0;
    sel_full     = 1'b0;
    sel_in_range = (int'(in_sel) < N_OUT);
    for (int i = 0; i < N_OUT; i++) begin
      full[i] = (cnt_q[i] == 2'd2);
      if (int'(in_sel) == i) sel_full = full[i];
    end
    if (in_bcast)          in_ready = ~(|full);
    else if (sel_in_range) in_ready = ~sel_full;
    else                   in_ready = 1'b1;
    accept = in_valid & in_ready;
  end

  // Per-channel push/pop decode and next-state for pointers, occupancy and drops.
  always_comb begin
    push   = '0;
    pop    = '0;
    drop_d = drop_q;
    for (int i = 0; i < N_OUT; i++) begin
      push[i]   = accept & (in_bcast | (sel_in_range & (int'(in_sel) == i)));
      pop[i]    = (cnt_q[i] != 2'd0) & out_ready[i];
      wptr_d[i] = push[i] ? ~wptr_q[i] : wptr_q[i];
      rptr_d[i] = pop[i]  ? ~rptr_q[i] : rptr_q[i];
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
        2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    if (accept && !in_bcast && !sel_in_range) drop_d = sat_inc(drop_q);
  end

  // State registers; reset empties every FIFO and clears its storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
      for (int i = 0; i < N_OUT; i++) begin
        cnt_q[i]     <= 2'd0;
        wptr_q[i]    <= 1'b0;
        rptr_q[i]    <= 1'b0;
        mem_q[i][0]  <= '0;
        mem_q[i][1]  <= '0;
      end
    end else begin
      drop_q <= drop_d;
      for (int i = 0; i < N_OUT; i++) begin
        cnt_q[i]  <= cnt_d[i];
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        if (push[i]) mem_q[i][wptr_q[i]] <= in_data;
      end
    end
  end

  // Output view: head entry and non-empty flag of each FIFO.
  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      out_valid[i]                  = (cnt_q[i] != 2'd0);
      out_data[i*DATA_W +: DATA_W]  = mem_q[i][rptr_q[i]];
    end
    drop_cnt = drop_q;
  end

endmodule

// File: tb/tb_stream_demux.sv
// Testbench for stream_demux: a 4-channel instance exercised through a
// per-channel expected-word scoreboard, plus a 3-channel instance used for
// out-of-range select drops and counter saturation.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, in_bcast;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;

  logic        in_valid3, in_ready3, in_bcast3;
  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic [2:0]  out_valid3, out_ready3;
  logic [23:0] out_data3;
  logic [7:0]  drop_cnt3;

  int vecs = 0;
  int errs = 0;
  logic [7:0] exp_q [0:3][$];

  always #5 clk = ~clk;

  stream_demux #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  stream_demux #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .in_sel(in_sel3), .in_bcast(in_bcast3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .drop_cnt(drop_cnt3)
  );

  // Scoreboard consumer: every completed output handshake pops and compares.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          vecs++;
          if (exp_q[i].size() == 0) begin
            errs++;
            $display("FAIL sb_ch%0d unexpected word: got %h, expected none", i, out_data[i*8 +: 8]);
          end else begin
            logic [7:0] e;
            e = exp_q[i].pop_front();
            if (out_data[i*8 +: 8] !== e) begin
              errs++;
              $display("FAIL sb_ch%0d data: got %h, expected %h", i, out_data[i*8 +: 8], e);
            end
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs + 1);
    $fatal(1, "timeout");
  end

  // Present one word for one cycle; returns in_ready as seen during that cycle.
  task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic b,
                       output logic rdy);
    in_data  = d;
    in_sel   = s;
    in_bcast = b;
    in_valid = 1'b1;
    #2;
    rdy = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bcast = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    #1;
    vecs++; if (out_valid !== 4'h0) begin errs++; $display("FAIL reset_valid: got %h, expected 0", out_valid); end
    vecs++; if (out_data !== 32'h0) begin errs++; $display("FAIL reset_data: got %h, expected 0", out_data); end
    vecs++; if (drop_cnt !== 8'h0) begin errs++; $display("FAIL reset_drop: got %h, expected 0", drop_cnt); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b, expected 1", in_ready); end
    vecs++; if (drop_cnt3 !== 8'h0) begin errs++; $display("FAIL reset_drop3: got %h, expected 0", drop_cnt3); end
    vecs++; if (in_ready3 !== 1'b1) begin errs++; $display("FAIL reset_ready3: got %b, expected 1", in_ready3); end
  endtask

  task automatic test_route();
    logic rdy;
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'hA0 + 8'(i);
      exp_q[i].push_back(d);
      drive(d, 2'(i), 1'b0, rdy);
      vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL route_ready ch%0d: got %b, expected 1", i, rdy); end
      vecs++; if (out_valid[i] !== 1'b1) begin errs++; $display("FAIL route_latency ch%0d: got %b, expected 1", i, out_valid[i]); end
      vecs++; if (out_data[i*8 +: 8] !== d) begin errs++; $display("FAIL route_data ch%0d: got %h, expected %h", i, out_data[i*8 +: 8], d); end
    end
    idle(2);
    vecs++; if (out_valid !== 4'h0) begin errs++; $display("FAIL route_drained: got %h, expected 0", out_valid); end
    vecs++; if (drop_cnt !== 8'h0) begin errs++; $display("FAIL route_drop: got %h, expected 0", drop_cnt); end
  endtask

  task automatic test_backpressure();
    logic rdy;
    out_ready = 4'b1011;
    exp_q[2].push_back(8'h11);
    drive(8'h11, 2'd2, 1'b0, rdy);
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL bp_first: got %b, expected 1", rdy); end
    exp_q[2].push_back(8'h22);
    drive(8'h22, 2'd2, 1'b0, rdy);
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL bp_second: got %b, expected 1", rdy); end
    exp_q[0].push_back(8'h44);
    drive(8'h44, 2'd0, 1'b0, rdy);
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL bp_other_ch: got %b, expected 1", rdy); end
    drive(8'h33, 2'd2, 1'b0, rdy);
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL bp_third_stall: got %b, expected 0", rdy); end
    vecs++; if (out_data[23:16] !== 8'h11 || out_valid[2] !== 1'b1) begin
      errs++; $display("FAIL bp_hold: got v=%b d=%h, expected v=1 d=11", out_valid[2], out_data[23:16]);
    end
    out_ready = 4'hF;
    idle(1);
    exp_q[2].push_back(8'h33);
    drive(8'h33, 2'd2, 1'b0, rdy);
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL bp_third_retry: got %b, expected 1", rdy); end
    idle(3);
    vecs++; if (out_valid !== 4'h0) begin errs++; $display("FAIL bp_drained: got %h, expected 0", out_valid); end
  endtask

  task automatic test_bcast();
    logic rdy;
    out_ready = 4'b1101;
    exp_q[1].push_back(8'h01);
    drive(8'h01, 2'd1, 1'b0, rdy);
    exp_q[1].push_back(8'h02);
    drive(8'h02, 2'd1, 1'b0, rdy);
    drive(8'h5A, 2'd3, 1'b1, rdy);
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL bcast_blocked: got %b, expected 0", rdy); end
    vecs++; if (out_valid !== 4'b0010) begin errs++; $display("FAIL bcast_none: got %b, expected 0010", out_valid); end
    out_ready = 4'hF;
    idle(2);
    for (int i = 0; i < 4; i++) exp_q[i].push_back(8'h5A);
    drive(8'h5A, 2'd3, 1'b1, rdy);
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL bcast_accept: got %b, expected 1", rdy); end
    vecs++; if (out_valid !== 4'hF) begin errs++; $display("FAIL bcast_valid: got %b, expected 1111", out_valid); end
    vecs++; if (out_data !== 32'h5A5A5A5A) begin errs++; $display("FAIL bcast_data: got %h, expected 5a5a5a5a", out_data); end
    idle(2);
    vecs++; if (out_valid !== 4'h0) begin errs++; $display("FAIL bcast_drained: got %h, expected 0", out_valid); end
  endtask

  task automatic test_push_pop();
    logic rdy;
    out_ready = 4'h0;
    exp_q[0].push_back(8'h66);
    drive(8'h66, 2'd0, 1'b0, rdy);
    out_ready = 4'b0001;
    exp_q[0].push_back(8'h77);
    drive(8'h77, 2'd0, 1'b0, rdy);
    out_ready = 4'h0;
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL pp_accept: got %b, expected 1", rdy); end
    vecs++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h77) begin
      errs++; $display("FAIL pp_head: got v=%b d=%h, expected v=1 d=77", out_valid[0], out_data[7:0]);
    end
    exp_q[0].push_back(8'h88);
    drive(8'h88, 2'd0, 1'b0, rdy);
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL pp_occ_one: got %b, expected 1", rdy); end
    drive(8'h99, 2'd0, 1'b0, rdy);
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL pp_full: got %b, expected 0", rdy); end
    vecs++; if (out_data[7:0] !== 8'h77) begin errs++; $display("FAIL pp_stable: got %h, expected 77", out_data[7:0]); end
    out_ready = 4'hF;
    idle(3);
    vecs++; if (out_valid !== 4'h0) begin errs++; $display("FAIL pp_drained: got %h, expected 0", out_valid); end
  endtask

  task automatic test_drop();
    logic [7:0] exp_cnt;
    in_sel3   = 2'd3;
    in_valid3 = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      in_data3 = 8'($urandom);
      #2;
      vecs++; if (in_ready3 !== 1'b1) begin errs++; $display("FAIL drop_ready at %0d: got %b, expected 1", k, in_ready3); end
      vecs++; if (out_valid3 !== 3'b000) begin errs++; $display("FAIL drop_valid at %0d: got %b, expected 000", k, out_valid3); end
      @(posedge clk);
      #1;
      exp_cnt = (k < 255) ? 8'(k) : 8'd255;
      vecs++; if (drop_cnt3 !== exp_cnt) begin errs++; $display("FAIL drop_cnt at %0d: got %0d, expected %0d", k, drop_cnt3, exp_cnt); end
    end
    in_valid3 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic rdy;
    out_ready = 4'h0;
    drive(8'hD1, 2'd0, 1'b0, rdy);
    drive(8'hD2, 2'd3, 1'b0, rdy);
    drive(8'hD3, 2'd3, 1'b0, rdy);
    out_ready = 4'hF;
    in_data   = 8'hEE;
    in_sel    = 2'd1;
    in_valid  = 1'b1;
    rst       = 1'b1;
    idle(1);
    in_valid  = 1'b0;
    rst       = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    vecs++; if (out_valid !== 4'h0) begin errs++; $display("FAIL rmid_valid: got %h, expected 0", out_valid); end
    vecs++; if (out_data !== 32'h0) begin errs++; $display("FAIL rmid_data: got %h, expected 0", out_data); end
    vecs++; if (drop_cnt !== 8'h0) begin errs++; $display("FAIL rmid_drop: got %h, expected 0", drop_cnt); end
    vecs++; if (drop_cnt3 !== 8'h0) begin errs++; $display("FAIL rmid_drop3: got %h, expected 0", drop_cnt3); end
    exp_q[1].push_back(8'hC5);
    drive(8'hC5, 2'd1, 1'b0, rdy);
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL rmid_resume_ready: got %b, expected 1", rdy); end
    vecs++; if (out_valid !== 4'b0010 || out_data[15:8] !== 8'hC5) begin
      errs++; $display("FAIL rmid_resume: got v=%b d=%h, expected v=0010 d=c5", out_valid, out_data[15:8]);
    end
    idle(2);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0; in_bcast  = 1'b0; in_data  = 8'h0; in_sel  = 2'd0;
    out_ready  = 4'h0;
    in_valid3  = 1'b0; in_bcast3 = 1'b0; in_data3 = 8'h0; in_sel3 = 2'd0;
    out_ready3 = 3'b111;
    @(posedge clk);
    #1;
    test_reset();
    test_route();
    test_backpressure();
    test_bcast();
    test_push_pop();
    test_drop();
    test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (exp_q[i].size() != 0) begin
        errs++; $display("FAIL sb_leftover ch%0d: got %0d words pending, expected 0", i, exp_q[i].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised 1-to-N stream demultiplexer with valid/ready handshakes and per-channel buffering. This is the next generation of the team's combinational 1-to-4 demux. It routes each accepted input word to the output selected by `in_sel`, or to all outputs in broadcast mode. Each output has a 2-entry FIFO so one stalled consumer never corrupts another. It sits between a single producer (e.g. a packet or sample source) and N independent consumers.

## Interface
- `DATA_W`, 8, payload width in bits (≥1)
- `N_OUT`, 4, number of output channels (2..16)
- `SEL_W`, 2, select width; 2^SEL_W ≥ N_OUT is required (elaboration-time check)
- `CNT_W`, 8, drop counter width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  block accepts the word this cycle
- `in_data`  in  DATA_W  payload
- `in_sel`  in  SEL_W  destination channel index
- `in_bcast`  in  1  1 = send to every channel; `in_sel` is ignored
- `out_valid`  out  N_OUT  bit i: channel i FIFO non-empty
- `out_ready`  in  N_OUT  bit i: consumer i takes head word
- `out_data`  out  N_OUT*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- `drop_cnt`  out  CNT_W  count of words dropped for an out-of-range select

## Operation
- Transfer on input when `in_valid && in_ready`. Transfer on channel i when `out_valid[i] && out_ready[i]`.
- Per channel: 2-entry FIFO with a 2-bit occupancy count (0, 1 or 2), a write pointer and a read pointer. `out_data[i]` = head entry. `out_valid[i]` = occupancy ≠ 0.
- `in_ready` is combinational from FIFO occupancy, `in_sel` and `in_bcast` only. It never depends on `out_ready`:
  - `in_bcast=1`: high when no FIFO is full.
  - `in_bcast=0`, `in_sel < N_OUT`: high when FIFO[`in_sel`] is not full.
  - `in_bcast=0`, `in_sel ≥ N_OUT`: high unconditionally. The word is discarded and `drop_cnt` increments, saturating at 2^CNT_W−1.
- Broadcast is atomic. The word is pushed into all N FIFOs in the same cycle, or into none.
- Push and pop on the same channel in the same cycle: occupancy is unchanged and both pointers advance. This is only possible when occupancy is 1, because a full FIFO has `in_ready` low for that target.
- Pop on an empty FIFO cannot occur, since `out_valid` gates it. Push on a full FIFO cannot occur, since `in_ready` gates it.
- Word order is preserved per channel. There is no ordering relation between channels.
- `in_valid=0`: no state change other than pops.

## Timing
- Reset, applied at a rising edge with `rst=1`:
  - all occupancies 0 and pointers 0
  - `out_valid` = 0, `out_data` = 0 (FIFO storage cleared), `drop_cnt` = 0
  - `in_ready` follows its rule, so it is high after reset.
- Reset mid-operation discards all buffered words. No output handshake completes in the reset cycle.
- Latency: a word accepted at edge k appears with `out_valid[i]=1` in the cycle after edge k, i.e. 1 cycle. There is no combinational path from input to output.
- Throughput: 1 word/cycle per channel when the consumer holds `out_ready=1`. The 2-entry FIFO sustains full rate without a combinational ready path.
- A full channel stalls only input words targeted at it, plus broadcasts. Words for other channels proceed.
- `out_data[i]` is stable while `out_valid[i]=1 && out_ready[i]=0`.

## Test plan
- Reset, then `in_sel`=0..3 with data 0xA0..0xA3, all `out_ready`=1 → each `out_valid[i]` pulses one cycle after its input; `out_data[i]`=0xA0+i; `drop_cnt`=0.
- `out_ready[2]`=0, send 0x11, 0x22, 0x33 to channel 2 → first two accepted, `in_ready`=0 on the third. Raise `out_ready[2]` → data 0x11, 0x22, 0x33 emitted in order.
- Channel 1 full, `in_bcast`=1 with 0x5A → `in_ready`=0 and no channel receives it. Drain channel 1 → broadcast accepted and all four channels present 0x5A on the following cycle.
- `N_OUT`=3, `SEL_W`=2, `in_sel`=3 for 300 consecutive valid cycles → `in_ready`=1 throughout, no `out_valid`, `drop_cnt` saturates at 255.
- Channel 0 at occupancy 1, simultaneous push 0x77 and pop → occupancy stays 1; the next head is 0x77.
- Assert `rst` while channels hold data and words are in flight → on the next cycle all `out_valid`=0, `out_data`=0, `drop_cnt`=0; normal traffic resumes afterwards.
